// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the I-side and D-side
// requesters. Each access takes one cycle and the response arrives two cycles after its grant.
module mem_port_arbiter #(
  parameter int MEM_WORDS    = 128,
  parameter bit RESET_LAST_D = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [30:0] WORD_LIMIT = 31'(MEM_WORDS);

  state_t      state_reg, state_next;
  logic        last_d_reg;
  logic        owner_d_reg;
  logic        we_reg;
  logic        err_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic        i_rvalid_reg, d_rvalid_reg;
  logic        i_err_reg, d_err_reg;
  logic [31:0] i_rdata_reg, d_rdata_reg;

  logic        arb_open;
  logic        grant_i, grant_d;
  logic [31:0] sel_addr;
  logic        sel_err;
  logic        in_access;

  // A grant can only be issued while the memory slot for the next cycle is free.
  assign arb_open  = (state_reg != ACCESS) && !reset;
  assign in_access = (state_reg == ACCESS);

  // On a tie, last_d_reg = 1 hands the slot to the I-side and vice versa.
  assign grant_i = arb_open && i_req && (!d_req || last_d_reg);
  assign grant_d = arb_open && d_req && (!i_req || !last_d_reg);

  assign sel_addr = grant_d ? d_addr : i_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr[31:2]} >= WORD_LIMIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = (grant_i || grant_d) ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = (grant_i || grant_d) ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_d_reg   <= RESET_LAST_D;
      owner_d_reg  <= 1'b0;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      i_err_reg    <= 1'b0;
      d_err_reg    <= 1'b0;
      i_rdata_reg  <= 32'h0;
      d_rdata_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      i_err_reg    <= 1'b0;
      d_err_reg    <= 1'b0;

      if (grant_i || grant_d) begin
        last_d_reg  <= grant_d;
        owner_d_reg <= grant_d;
        addr_reg    <= sel_addr;
        we_reg      <= grant_d && d_we;
        err_reg     <= sel_err;
        if (grant_d) begin
          wdata_reg <= d_wdata;
        end
      end

      // Close the access: capture read data for the owner; stores leave d_rdata alone.
      if (in_access) begin
        if (owner_d_reg) begin
          d_rvalid_reg <= 1'b1;
          d_err_reg    <= err_reg;
          if (!we_reg) begin
            d_rdata_reg <= err_reg ? 32'h0 : mem_rd;
          end
        end else begin
          i_rvalid_reg <= 1'b1;
          i_err_reg    <= err_reg;
          i_rdata_reg  <= err_reg ? 32'h0 : mem_rd;
        end
      end
    end
  end

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign i_rvalid = i_rvalid_reg;
  assign i_rdata  = i_rdata_reg;
  assign i_err    = i_err_reg;
  assign d_rvalid = d_rvalid_reg;
  assign d_rdata  = d_rdata_reg;
  assign d_err    = d_err_reg;

  assign mem_addr = addr_reg;
  assign mem_wd   = wdata_reg;
  assign mem_we   = in_access && we_reg && owner_d_reg && !err_reg && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 128-word memory model that writes on the falling edge.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] tb_mem [0:127];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Memory decodes only the low word-index bits, so out-of-range addresses alias.
  assign mem_rd = tb_mem[mem_addr[8:2]];
  always @(negedge CLK) if (mem_we) tb_mem[mem_addr[8:2]] <= mem_wd;

  mem_port_arbiter #(.MEM_WORDS(128), .RESET_LAST_D(1'b1)) dut (
    .CLK(CLK), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    tick(); tick();
    d_req = 1'b1;
    #1;
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", d_gnt); end
    checks++; if ({i_rvalid, d_rvalid, i_err, d_err, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {i_rvalid, d_rvalid, i_err, d_err, mem_we}); end
    checks++; if ({i_rdata, d_rdata, mem_addr, mem_wd} !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {i_rdata, d_rdata, mem_addr, mem_wd}); end
    d_req = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h0;
    #1;
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got %b exp 1", i_gnt); end
    tick(); i_req = 1'b0; #1;
    checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0 || i_gnt !== 1'b0) begin errors++; $display("FAIL fetch_access got addr=%h we=%b gnt=%b exp 0 0 0", mem_addr, mem_we, i_gnt); end
    tick();
    checks++; if ({i_rvalid, i_err, i_rdata} !== {2'b10, 32'h20110001}) begin errors++; $display("FAIL fetch_resp got v=%b e=%b d=%h exp 1 0 20110001", i_rvalid, i_err, i_rdata); end
    $display("txn fetch addr=00000000 rdata=%h err=%b", i_rdata, i_err);
    tick();
    checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", i_rvalid); end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL store_gnt got gnt=%b we=%b exp 1 0", d_gnt, mem_we); end
    tick(); d_req = 1'b0; #1;
    checks++; if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h40, 32'hDEADBEEF}) begin errors++; $display("FAIL store_access got we=%b a=%h wd=%h exp 1 40 deadbeef", mem_we, mem_addr, mem_wd); end
    tick();
    checks++; if ({d_rvalid, d_err, mem_we, d_rdata} !== {3'b100, 32'h0}) begin errors++; $display("FAIL store_resp got v=%b e=%b we=%b d=%h exp 1 0 0 0", d_rvalid, d_err, mem_we, d_rdata); end
    checks++; if (tb_mem[16] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_mem got %h exp deadbeef", tb_mem[16]); end
    $display("txn store addr=00000040 wdata=deadbeef err=%b", d_err);
    d_req = 1'b1; d_we = 1'b0;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt_in_resp got %b exp 1", d_gnt); end
    tick(); d_req = 1'b0; tick();
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL load_resp got v=%b e=%b d=%h exp 1 0 deadbeef", d_rvalid, d_err, d_rdata); end
    $display("txn load addr=00000040 rdata=%h err=%b", d_rdata, d_err);
    tick();
  endtask

  task automatic test_contention();
    logic exp_ig, exp_dg, exp_iv, exp_dv;
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 0; c < 9; c++) begin
      if (c == 7) begin i_req = 1'b0; d_req = 1'b0; end
      #1;
      exp_ig = (c % 4 == 0) && (c < 8);
      exp_dg = (c % 4 == 2);
      exp_iv = (c % 4 == 2);
      exp_dv = (c % 4 == 0) && (c >= 4);
      checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== {exp_ig, exp_dg, exp_iv, exp_dv}) begin errors++; $display("FAIL contention_c%0d got gi=%b gd=%b vi=%b vd=%b exp %b %b %b %b", c, i_gnt, d_gnt, i_rvalid, d_rvalid, exp_ig, exp_dg, exp_iv, exp_dv); end
      if (exp_iv) begin
        checks++; if (i_rdata !== 32'h20110001) begin errors++; $display("FAIL contention_idata got %h exp 20110001", i_rdata); end
        $display("txn contention fetch cycle=%0d rdata=%h", c, i_rdata);
      end
      if (exp_dv) begin
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL contention_ddata got %h exp deadbeef", d_rdata); end
        $display("txn contention load cycle=%0d rdata=%h", c, d_rdata);
      end
      tick();
    end
  endtask

  task automatic test_errors();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h41; d_wdata = 32'h12345678;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL err_store_gnt got %b exp 1", d_gnt); end
    tick(); d_req = 1'b0; #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL err_store_we got %b exp 0", mem_we); end
    tick();
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'hDEADBEEF}) begin errors++; $display("FAIL err_store_resp got v=%b e=%b d=%h exp 1 1 deadbeef", d_rvalid, d_err, d_rdata); end
    checks++; if (tb_mem[16] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_store_mem got %h exp deadbeef", tb_mem[16]); end
    $display("txn store addr=00000041 err=%b", d_err);
    i_req = 1'b1; i_addr = 32'h200;
    #1;
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL err_fetch_gnt got %b exp 1", i_gnt); end
    tick(); i_req = 1'b0; tick();
    checks++; if ({i_rvalid, i_err, i_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_fetch_resp got v=%b e=%b d=%h exp 1 1 0", i_rvalid, i_err, i_rdata); end
    $display("txn fetch addr=00000200 rdata=%h err=%b", i_rdata, i_err);
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hCAFEF00D;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", d_gnt); end
    tick(); d_req = 1'b0; reset = 1'b1; #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %b exp 0", mem_we); end
    tick(); i_req = 1'b1; i_addr = 32'h0; #1;
    checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, mem_we} !== 7'b0) begin errors++; $display("FAIL rmid_flags got %b exp 0000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, mem_we}); end
    checks++; if ({i_rdata, d_rdata, mem_addr, mem_wd} !== 128'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", {i_rdata, d_rdata, mem_addr, mem_wd}); end
    checks++; if (tb_mem[17] !== 32'h0) begin errors++; $display("FAIL rmid_mem got %h exp 0", tb_mem[17]); end
    $display("txn store addr=00000044 dropped by reset");
    i_req = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps [3];
    addrs[0] = 32'h0;  exps[0] = 32'h20110001;
    addrs[1] = 32'h40; exps[1] = 32'hDEADBEEF;
    addrs[2] = 32'h4;  exps[2] = 32'h00001111;
    for (int k = 0; k < 3; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = addrs[k];
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b exp 1", k, d_gnt); end
      if (k > 0) begin
        checks++; if ({d_rvalid, d_rdata} !== {1'b1, exps[k-1]}) begin errors++; $display("FAIL b2b_resp%0d got v=%b d=%h exp 1 %h", k - 1, d_rvalid, d_rdata, exps[k-1]); end
        $display("txn b2b load %0d rdata=%h", k - 1, d_rdata);
      end
      tick();
      if (k == 2) d_req = 1'b0;
      #1;
      checks++; if ({d_gnt, d_rvalid} !== 2'b00) begin errors++; $display("FAIL b2b_access%0d got gnt=%b v=%b exp 0 0", k, d_gnt, d_rvalid); end
      tick();
    end
    #1;
    checks++; if ({d_rvalid, d_gnt, d_rdata} !== {2'b10, exps[2]}) begin errors++; $display("FAIL b2b_resp2 got v=%b g=%b d=%h exp 1 0 %h", d_rvalid, d_gnt, d_rdata, exps[2]); end
    $display("txn b2b load 2 rdata=%h", d_rdata);
    tick();
  endtask

  initial begin
    for (int w = 0; w < 128; w++) tb_mem[w] = 32'h0;
    tb_mem[0] = 32'h20110001;
    tb_mem[1] = 32'h00001111;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
